uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchronizer, mid-bit sampling, framing error and break detection
`ifndef UART_DATA_LENGTH
`define UART_DATA_LENGTH 8
`endif

module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [`UART_DATA_LENGTH-1:0] rx_o,
    output logic                         rx_o_v,
    output logic                         frame_err_o,
    output logic                         busy_o
);
    localparam int W  = `UART_DATA_LENGTH;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    localparam logic [7:0]    HALF = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0]    FULL = 8'(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic [1:0]    sync;
    logic          rx_s;
    logic [2:0]    state;
    logic [7:0]    cnt;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  shreg;

    assign rx_s   = sync[1];
    assign busy_o = (state != IDLE);

    // cnt counts cycles since the previous sample point; a bit is sampled when it reaches HALF/FULL
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= 8'd0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_o        <= '0;
            rx_o_v      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_i};
            rx_o_v      <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt     <= 8'd1;
                        bit_cnt <= '0;
                        // with no half-bit offset the start sample is this very cycle
                        state   <= (HALF == 8'd0) ? DATA : START;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= 8'd1;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= 8'd1;
                        shreg <= {rx_s, shreg[W-1:1]};
                        if (bit_cnt == LAST) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL) begin
                        cnt <= 8'd0;
                        if (rx_s) begin
                            rx_o   <= shreg;
                            rx_o_v <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - three uart_rx instances (1, 16, 5 clocks per bit) checked against a frame-timing model
module tb_uart_rx;
    localparam int N = 800;
    localparam int W = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rx_in  [NI];
    logic         rst_in [NI];
    logic [W-1:0] rxo    [NI];
    logic         rxv    [NI];
    logic         rxe    [NI];
    logic         rxb    [NI];

    uart_rx #(.CLKS_PER_BIT(1)) u0 (
        .clk_i(clk), .rst_i(rst_in[0]), .rx_i(rx_in[0]),
        .rx_o(rxo[0]), .rx_o_v(rxv[0]), .frame_err_o(rxe[0]), .busy_o(rxb[0])
    );
    uart_rx #(.CLKS_PER_BIT(16)) u1 (
        .clk_i(clk), .rst_i(rst_in[1]), .rx_i(rx_in[1]),
        .rx_o(rxo[1]), .rx_o_v(rxv[1]), .frame_err_o(rxe[1]), .busy_o(rxb[1])
    );
    uart_rx #(.CLKS_PER_BIT(5)) u2 (
        .clk_i(clk), .rst_i(rst_in[2]), .rx_i(rx_in[2]),
        .rx_o(rxo[2]), .rx_o_v(rxv[2]), .frame_err_o(rxe[2]), .busy_o(rxb[2])
    );

    int cpb [NI] = '{1, 16, 5};

    bit       line_a [NI][N];
    bit       rst_a  [NI][N];
    bit       rs_m   [NI][N];
    bit       e_v    [NI][N];
    bit       e_err  [NI][N];
    bit       e_busy [NI][N];
    bit [7:0] e_word [NI][N];
    bit [7:0] e_rxo  [NI][N];

    bit [7:0] d_rxo  [NI][N];
    bit       d_v    [NI][N];
    bit       d_err  [NI][N];
    bit       d_busy [NI][N];

    int checks = 0;
    int failures = 0;
    int cyc = -1;
    bit running = 1'b0;

    task automatic put_frame(input int i, input int start, input bit [7:0] data,
                             input int stop_len, input bit stop_val);
        int p;
        p = start;
        for (int k = 0; k <= W; k++) begin
            for (int j = 0; j < cpb[i]; j++) begin
                line_a[i][p] = (k == 0) ? 1'b0 : data[k-1];
                p++;
            end
        end
        for (int j = 0; j < stop_len; j++) begin
            line_a[i][p] = stop_val;
            p++;
        end
    endtask

    // Expected outputs from frame timing: bit k of a frame whose start edge is seen at t0
    // is sampled at t0+H+k*C, and the result of the stop sample appears one cycle later.
    task automatic build_model(input int i);
        int c_bit, h, d, t0, ts, lim, r, b;
        bit [7:0] word, cur;
        c_bit = cpb[i];
        h = (c_bit - 1) / 2;
        for (int c = 0; c < N; c++) begin
            if (c < 2 || rst_a[i][c] || rst_a[i][c-1] || rst_a[i][c-2]) rs_m[i][c] = 1'b1;
            else rs_m[i][c] = line_a[i][c-2];
            e_v[i][c] = 0; e_err[i][c] = 0; e_busy[i][c] = 0; e_word[i][c] = 0;
        end
        d = 0;
        while (d < N) begin
            if (rst_a[i][d] || rs_m[i][d]) begin
                d++;
                continue;
            end
            t0 = d;
            ts = t0 + h + (W + 1) * c_bit;
            if (ts + 1 >= N) break;
            lim = rs_m[i][t0+h] ? t0 + h : ts;
            r = -1;
            for (int c = t0 + 1; c <= lim; c++) if (r < 0 && rst_a[i][c]) r = c;
            if (r >= 0) begin
                for (int c = t0 + 1; c < r; c++) e_busy[i][c] = 1;
                d = r;
                continue;
            end
            if (rs_m[i][t0+h]) begin
                for (int c = t0 + 1; c <= t0 + h; c++) e_busy[i][c] = 1;
                d = t0 + h + 1;
                continue;
            end
            word = 0;
            for (int k = 1; k <= W; k++) word[k-1] = rs_m[i][t0+h+k*c_bit];
            for (int c = t0 + 1; c <= ts; c++) e_busy[i][c] = 1;
            if (rs_m[i][ts]) begin
                e_v[i][ts+1] = 1;
                e_word[i][ts+1] = word;
                d = ts + 1;
            end else begin
                e_err[i][ts+1] = 1;
                b = ts + 1;
                while (b < N && !rs_m[i][b] && !rst_a[i][b]) begin
                    e_busy[i][b] = 1;
                    b++;
                end
                if (b < N && !rst_a[i][b]) begin
                    e_busy[i][b] = 1;
                    d = b + 1;
                end else begin
                    d = b;
                end
            end
        end
        cur = 0;
        for (int c = 0; c < N; c++) begin
            if (rst_a[i][c]) begin
                e_v[i][c] = 0; e_err[i][c] = 0; e_busy[i][c] = 0;
                cur = 0;
            end else if (e_v[i][c]) begin
                cur = e_word[i][c];
            end
            e_rxo[i][c] = cur;
        end
    endtask

    task automatic check(input string name, input int i, input int c, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, i, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (running && cyc >= 0 && cyc < N) begin
            for (int i = 0; i < NI; i++) begin
                d_rxo[i][cyc] = rxo[i]; d_v[i][cyc] = rxv[i];
                d_err[i][cyc] = rxe[i]; d_busy[i][cyc] = rxb[i];
                check("rx_o", i, cyc, rxo[i], e_rxo[i][cyc]);
                check("rx_o_v", i, cyc, rxv[i], e_v[i][cyc]);
                check("frame_err_o", i, cyc, rxe[i], e_err[i][cyc]);
                check("busy_o", i, cyc, rxb[i], e_busy[i][cyc]);
            end
        end
    end

    initial begin
        int npulse;
        for (int i = 0; i < NI; i++) begin
            rx_in[i] = 1'b1;
            rst_in[i] = 1'b1;
            for (int c = 0; c < N; c++) begin
                line_a[i][c] = 1'b1;
                rst_a[i][c] = (c < 3);
            end
        end
        put_frame(0, 10, 8'h4A, 1, 1'b1);
        put_frame(0, 40, 8'hA5, 1, 1'b1);
        put_frame(0, 51, 8'h3C, 1, 1'b1);
        put_frame(0, 80, 8'h11, 1, 1'b1);
        put_frame(0, 90, 8'h22, 1, 1'b1);
        put_frame(1, 20, 8'h7E, 16, 1'b1);
        put_frame(1, 200, 8'hFF, 40, 1'b0);
        for (int c = 420; c < 423; c++) line_a[1][c] = 1'b0;
        put_frame(1, 460, 8'h55, 16, 1'b1);
        for (int c = 545; c < 600; c++) line_a[1][c] = 1'b1;
        rst_a[1][545] = 1'b1;
        rst_a[1][546] = 1'b1;
        put_frame(1, 600, 8'h81, 16, 1'b1);
        put_frame(2, 30, 8'h00, 5, 1'b1);
        put_frame(2, 100, 8'hC3, 5, 1'b1);
        for (int i = 0; i < NI; i++) build_model(i);

        running = 1'b1;
        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            for (int i = 0; i < NI; i++) begin
                rx_in[i] = line_a[i][c];
                rst_in[i] = rst_a[i][c];
            end
        end
        @(negedge clk);
        running = 1'b0;
        #1;

        check("reset_busy", 1, 1, d_busy[1][1], 0);
        check("reset_rxo", 0, 1, d_rxo[0][1], 0);
        check("v_4a", 0, 22, d_v[0][22], 1);
        check("rxo_4a", 0, 22, d_rxo[0][22], 8'h4A);
        check("v_a5", 0, 52, d_v[0][52], 1);
        check("rxo_a5", 0, 52, d_rxo[0][52], 8'hA5);
        check("v_3c", 0, 63, d_v[0][63], 1);
        check("rxo_3c", 0, 63, d_rxo[0][63], 8'h3C);
        check("v_11", 0, 92, d_v[0][92], 1);
        check("rxo_22", 0, 102, d_rxo[0][102], 8'h22);
        check("v_7e", 1, 174, d_v[1][174], 1);
        check("err_ff", 1, 354, d_err[1][354], 1);
        check("rxo_kept", 1, 400, d_rxo[1][400], 8'h7E);
        check("break_busy", 1, 386, d_busy[1][386], 1);
        check("break_idle", 1, 387, d_busy[1][387], 0);
        check("glitch_busy", 1, 429, d_busy[1][429], 1);
        check("glitch_idle", 1, 430, d_busy[1][430], 0);
        check("v_81", 1, 754, d_v[1][754], 1);
        check("rxo_81", 1, 754, d_rxo[1][754], 8'h81);
        check("v_00", 2, 80, d_v[2][80], 1);
        check("v_c3", 2, 150, d_v[2][150], 1);
        check("rxo_c3", 2, 150, d_rxo[2][150], 8'hC3);
        npulse = 0;
        for (int c = 0; c < N; c++) npulse += d_v[1][c];
        check("pulses_inst1", 1, N, npulse, 2);
        npulse = 0;
        for (int c = 0; c < N; c++) npulse += d_err[0][c];
        check("errs_inst0", 0, N, npulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
